// File: rtl/irq_sequencer_if.sv
// rtl/irq_sequencer_if.sv - redirect handshake between irq_sequencer and the fetch PC mux
// Signals:
//   redirect_req  sequencer -> fetch  redirect pending
//   redirect_pc   sequencer -> fetch  redirect target, stable while redirect_req is high
//   redirect_ack  fetch -> sequencer  redirect accepted this cycle
interface irq_sequencer_if;
    logic        redirect_req;
    logic [31:0] redirect_pc;
    logic        redirect_ack;

    modport master (
        output redirect_req,
        output redirect_pc,
        input  redirect_ack
    );

    modport slave (
        input  redirect_req,
        input  redirect_pc,
        output redirect_ack
    );
endinterface

// File: rtl/irq_sequencer.sv
// rtl/irq_sequencer.sv - trap entry/return sequencer issuing registered PC redirects to fetch
// Ports:
//   i_clk, i_rst                 core clock, asynchronous active-high reset
//   i_nmi, i_int_req, i_tmr_req  interrupt levels, rising edges latched as pending
//   i_ecall, i_ebreak, i_mret    one-cycle decode pulses
//   i_pc_ret                     return address offered by decode this cycle
//   i_en_inter/ecall/int/tmr     global and per-source enables
//   redir (master)               redirect_req / redirect_pc / redirect_ack to fetch
//   o_trap_sel                   source served: NMI=0 EBREAK=1 TMR=2 INT=3 ECALL=4
//   o_epc                        saved return PC
//   o_in_handler                 core is executing a handler
// Optional feature macro: IRQ_NESTED_NMI_EN (one level of NMI preemption of a handler)
module irq_sequencer #(
    parameter logic [31:0] VEC_BASE = 32'h0000_0100
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_nmi,
    input  logic                  i_int_req,
    input  logic                  i_tmr_req,
    input  logic                  i_ecall,
    input  logic                  i_ebreak,
    input  logic                  i_mret,
    input  logic [31:0]           i_pc_ret,
    input  logic                  i_en_inter,
    input  logic                  i_en_ecall,
    input  logic                  i_en_int,
    input  logic                  i_en_tmr,
    irq_sequencer_if.master       redir,
    output logic [2:0]            o_trap_sel,
    output logic [31:0]           o_epc,
    output logic                  o_in_handler
);

    localparam logic [2:0] SEL_NMI    = 3'd0;
    localparam logic [2:0] SEL_EBREAK = 3'd1;
    localparam logic [2:0] SEL_TMR    = 3'd2;
    localparam logic [2:0] SEL_INT    = 3'd3;
    localparam logic [2:0] SEL_ECALL  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_ENTER       = 3'd1,
        S_HANDLER     = 3'd2,
        S_RETURN      = 3'd3
`ifdef IRQ_NESTED_NMI_EN
        ,
        S_NMI_ENTER   = 3'd4,
        S_NMI_HANDLER = 3'd5,
        S_NMI_RETURN  = 3'd6
`endif
    } state_t;

    state_t      r_state;
    state_t      w_state_n;

    logic        r_nmi_d, r_tmr_d, r_int_d;
    logic        r_nmi_p, r_tmr_p, r_int_p;

    logic        r_redirect_req;
    logic [31:0] r_redirect_pc;
    logic [2:0]  r_trap_sel;
    logic [31:0] r_epc;
    logic        r_in_handler;

    logic        w_req_n;
    logic [31:0] w_pc_n;
    logic [2:0]  w_sel_n;
    logic [31:0] w_epc_n;
    logic        w_handler_n;
    logic        w_clr_nmi, w_clr_tmr, w_clr_int;
    logic        w_elig_tmr, w_elig_int, w_elig_ecall;

`ifdef IRQ_NESTED_NMI_EN
    logic [31:0] r_epc2, w_epc2_n;
    logic [2:0]  r_sel_save, w_sel_save_n;
`endif

    function automatic logic [31:0] vec_addr(input logic [2:0] sel);
        return VEC_BASE + {25'd0, sel, 4'd0};
    endfunction

    // Maskable sources need both the global and their own enable; a masked
    // TMR/INT keeps its pending bit, a masked ECALL pulse simply evaporates.
    assign w_elig_tmr   = r_tmr_p & i_en_tmr & i_en_inter;
    assign w_elig_int   = r_int_p & i_en_int & i_en_inter;
    assign w_elig_ecall = i_ecall & i_en_ecall & i_en_inter;

    always_comb begin
        w_state_n   = r_state;
        w_req_n     = r_redirect_req;
        w_pc_n      = r_redirect_pc;
        w_sel_n     = r_trap_sel;
        w_epc_n     = r_epc;
        w_handler_n = r_in_handler;
        w_clr_nmi   = 1'b0;
        w_clr_tmr   = 1'b0;
        w_clr_int   = 1'b0;
`ifdef IRQ_NESTED_NMI_EN
        w_epc2_n     = r_epc2;
        w_sel_save_n = r_sel_save;
`endif
        case (r_state)
            S_IDLE: begin
                if (r_nmi_p) begin
                    w_sel_n   = SEL_NMI;
                    w_clr_nmi = 1'b1;
                    w_state_n = S_ENTER;
                end else if (i_ebreak) begin
                    w_sel_n   = SEL_EBREAK;
                    w_state_n = S_ENTER;
                end else if (w_elig_tmr) begin
                    w_sel_n   = SEL_TMR;
                    w_clr_tmr = 1'b1;
                    w_state_n = S_ENTER;
                end else if (w_elig_int) begin
                    w_sel_n   = SEL_INT;
                    w_clr_int = 1'b1;
                    w_state_n = S_ENTER;
                end else if (w_elig_ecall) begin
                    w_sel_n   = SEL_ECALL;
                    w_state_n = S_ENTER;
                end
                if (w_state_n == S_ENTER) begin
                    w_req_n = 1'b1;
                    w_pc_n  = vec_addr(w_sel_n);
                    w_epc_n = i_pc_ret;
                end
            end
            S_ENTER: begin
                if (redir.redirect_ack) begin
                    w_state_n   = S_HANDLER;
                    w_req_n     = 1'b0;
                    w_handler_n = 1'b1;
                end
            end
            S_HANDLER: begin
                // mret takes precedence over a same-cycle NMI; the NMI stays pending.
                if (i_mret) begin
                    w_state_n   = S_RETURN;
                    w_req_n     = 1'b1;
                    w_pc_n      = r_epc;
                    w_handler_n = 1'b0;
                end
`ifdef IRQ_NESTED_NMI_EN
                else if (r_nmi_p && (r_trap_sel != SEL_NMI)) begin
                    w_state_n    = S_NMI_ENTER;
                    w_req_n      = 1'b1;
                    w_pc_n       = vec_addr(SEL_NMI);
                    w_epc2_n     = i_pc_ret;
                    w_sel_save_n = r_trap_sel;
                    w_sel_n      = SEL_NMI;
                    w_clr_nmi    = 1'b1;
                    w_handler_n  = 1'b0;
                end
`endif
            end
            S_RETURN: begin
                if (redir.redirect_ack) begin
                    w_state_n = S_IDLE;
                    w_req_n   = 1'b0;
                end
            end
`ifdef IRQ_NESTED_NMI_EN
            S_NMI_ENTER: begin
                if (redir.redirect_ack) begin
                    w_state_n   = S_NMI_HANDLER;
                    w_req_n     = 1'b0;
                    w_handler_n = 1'b1;
                end
            end
            S_NMI_HANDLER: begin
                if (i_mret) begin
                    w_state_n   = S_NMI_RETURN;
                    w_req_n     = 1'b1;
                    w_pc_n      = r_epc2;
                    w_sel_n     = r_sel_save;
                    w_handler_n = 1'b0;
                end
            end
            S_NMI_RETURN: begin
                if (redir.redirect_ack) begin
                    w_state_n   = S_HANDLER;
                    w_req_n     = 1'b0;
                    w_handler_n = 1'b1;
                end
            end
`endif
            default: begin
                w_state_n = S_IDLE;
                w_req_n   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state        <= S_IDLE;
            r_nmi_d        <= 1'b0;
            r_tmr_d        <= 1'b0;
            r_int_d        <= 1'b0;
            r_nmi_p        <= 1'b0;
            r_tmr_p        <= 1'b0;
            r_int_p        <= 1'b0;
            r_redirect_req <= 1'b0;
            r_redirect_pc  <= 32'd0;
            r_trap_sel     <= SEL_ECALL;
            r_epc          <= 32'd0;
            r_in_handler   <= 1'b0;
`ifdef IRQ_NESTED_NMI_EN
            r_epc2         <= 32'd0;
            r_sel_save     <= SEL_ECALL;
`endif
        end else begin
            r_state        <= w_state_n;
            r_nmi_d        <= i_nmi;
            r_tmr_d        <= i_tmr_req;
            r_int_d        <= i_int_req;
            // A fresh edge re-arms the latch even in the cycle its old request is taken.
            r_nmi_p        <= (r_nmi_p & ~w_clr_nmi) | (i_nmi & ~r_nmi_d);
            r_tmr_p        <= (r_tmr_p & ~w_clr_tmr) | (i_tmr_req & ~r_tmr_d);
            r_int_p        <= (r_int_p & ~w_clr_int) | (i_int_req & ~r_int_d);
            r_redirect_req <= w_req_n;
            r_redirect_pc  <= w_pc_n;
            r_trap_sel     <= w_sel_n;
            r_epc          <= w_epc_n;
            r_in_handler   <= w_handler_n;
`ifdef IRQ_NESTED_NMI_EN
            r_epc2         <= w_epc2_n;
            r_sel_save     <= w_sel_save_n;
`endif
        end
    end

    assign redir.redirect_req = r_redirect_req;
    assign redir.redirect_pc  = r_redirect_pc;
    assign o_trap_sel         = r_trap_sel;
    assign o_epc              = r_epc;
    assign o_in_handler       = r_in_handler;

endmodule

// File: tb/tb_irq_sequencer.sv
// tb/tb_irq_sequencer.sv - self-checking bench for irq_sequencer (default build)
module tb_irq_sequencer;

    localparam logic [31:0] VEC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        nmi = 1'b0, int_req = 1'b0, tmr_req = 1'b0;
    logic        ecall = 1'b0, ebreak = 1'b0, mret = 1'b0;
    logic [31:0] pc_ret = 32'd0;
    logic        en_inter = 1'b0, en_ecall = 1'b0, en_int = 1'b0, en_tmr = 1'b0;
    logic [2:0]  trap_sel;
    logic [31:0] epc;
    logic        in_handler;

    int n_checks = 0;
    int n_fail   = 0;

    irq_sequencer_if u_if ();

    irq_sequencer #(.VEC_BASE(VEC)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_nmi        (nmi),
        .i_int_req    (int_req),
        .i_tmr_req    (tmr_req),
        .i_ecall      (ecall),
        .i_ebreak     (ebreak),
        .i_mret       (mret),
        .i_pc_ret     (pc_ret),
        .i_en_inter   (en_inter),
        .i_en_ecall   (en_ecall),
        .i_en_int     (en_int),
        .i_en_tmr     (en_tmr),
        .redir        (u_if),
        .o_trap_sel   (trap_sel),
        .o_epc        (epc),
        .o_in_handler (in_handler)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: trap codes double as priority rank (lower code wins),
    // pending latches are indexed by trap code; phases: 0 idle, 1 awaiting entry
    // ack, 2 in handler, 3 awaiting return ack.
    int          m_phase;
    logic        m_pend [0:4];
    logic        m_prev_nmi, m_prev_tmr, m_prev_int;
    logic        m_req;
    logic [31:0] m_pc;
    logic [2:0]  m_sel;
    logic [31:0] m_epc;
    logic        m_inh;

    function automatic logic eligible(input int k);
        case (k)
            0:       return m_pend[0];
            1:       return ebreak;
            2:       return m_pend[2] & en_tmr & en_inter;
            3:       return m_pend[3] & en_int & en_inter;
            default: return ecall & en_ecall & en_inter;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        int pick;
        if (rst) begin
            m_phase = 0;
            for (int k = 0; k < 5; k++) m_pend[k] = 1'b0;
            m_prev_nmi = 1'b0; m_prev_tmr = 1'b0; m_prev_int = 1'b0;
            m_req = 1'b0; m_pc = 32'd0; m_sel = 3'd4; m_epc = 32'd0; m_inh = 1'b0;
        end else begin
            case (m_phase)
                0: begin
                    pick = -1;
                    for (int k = 0; k < 5; k++)
                        if (pick < 0 && eligible(k)) pick = k;
                    if (pick >= 0) begin
                        m_sel        = pick[2:0];
                        m_epc        = pc_ret;
                        m_pc         = VEC + 32'(pick) * 32'd16;
                        m_req        = 1'b1;
                        m_pend[pick] = 1'b0;
                        m_phase      = 1;
                    end
                end
                1: if (u_if.redirect_ack) begin m_req = 1'b0; m_inh = 1'b1; m_phase = 2; end
                2: if (mret) begin m_req = 1'b1; m_pc = m_epc; m_inh = 1'b0; m_phase = 3; end
                default: if (u_if.redirect_ack) begin m_req = 1'b0; m_phase = 0; end
            endcase
            if (nmi && !m_prev_nmi)     m_pend[0] = 1'b1;
            if (tmr_req && !m_prev_tmr) m_pend[2] = 1'b1;
            if (int_req && !m_prev_int) m_pend[3] = 1'b1;
            m_prev_nmi = nmi; m_prev_tmr = tmr_req; m_prev_int = int_req;
        end
    end

    always @(negedge clk) begin
        chk("cmp_redirect_req", {31'd0, u_if.redirect_req}, {31'd0, m_req});
        if (m_req) chk("cmp_redirect_pc", u_if.redirect_pc, m_pc);
        chk("cmp_trap_sel", {29'd0, trap_sel}, {29'd0, m_sel});
        chk("cmp_epc", epc, m_epc);
        chk("cmp_in_handler", {31'd0, in_handler}, {31'd0, m_inh});
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_req(input string name, input int budget);
        int i;
        i = 0;
        while (!u_if.redirect_req && i < budget) begin
            @(negedge clk);
            i++;
        end
        if (!u_if.redirect_req) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: redirect_req still 0 after %0d cycles, expected 1", name, budget);
        end
    endtask

    task automatic ack_now();
        u_if.redirect_ack = 1'b1;
        @(negedge clk);
        u_if.redirect_ack = 1'b0;
    endtask

    task automatic pulse_mret();
        mret = 1'b1;
        @(negedge clk);
        mret = 1'b0;
    endtask

    // Take a pending/arriving trap, acknowledge entry, run the handler briefly, return.
    task automatic serve(input string name, input logic [31:0] vec, input logic [2:0] sel,
                         input logic [31:0] ret);
        wait_req(name, 8);
        chk({name, "_pc"}, u_if.redirect_pc, vec);
        chk({name, "_sel"}, {29'd0, trap_sel}, {29'd0, sel});
        chk({name, "_epc"}, epc, ret);
        ack_now();
        chk({name, "_inh"}, {31'd0, in_handler}, 32'd1);
        cyc(2);
        pulse_mret();
        chk({name, "_ret_pc"}, u_if.redirect_pc, ret);
        ack_now();
        chk({name, "_ret_done"}, {31'd0, u_if.redirect_req}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        u_if.redirect_ack = 1'b0;
        cyc(3);
        chk("rst_req", {31'd0, u_if.redirect_req}, 32'd0);
        chk("rst_pc", u_if.redirect_pc, 32'd0);
        chk("rst_sel", {29'd0, trap_sel}, 32'd4);
        chk("rst_epc", epc, 32'd0);
        chk("rst_inh", {31'd0, in_handler}, 32'd0);
        rst = 1'b0;
        cyc(2);

        // Timer: edge -> pending next cycle -> redirect the cycle after.
        en_tmr = 1'b1; en_inter = 1'b1; pc_ret = 32'h200; tmr_req = 1'b1;
        cyc(1);
        chk("tmr_req_early", {31'd0, u_if.redirect_req}, 32'd0);
        cyc(1);
        chk("tmr_req", {31'd0, u_if.redirect_req}, 32'd1);
        chk("tmr_pc", u_if.redirect_pc, 32'h120);
        chk("tmr_sel", {29'd0, trap_sel}, 32'd2);
        chk("tmr_epc", epc, 32'h200);
        cyc(2);
        chk("tmr_hold_pc", u_if.redirect_pc, 32'h120);
        ack_now();
        chk("tmr_inh", {31'd0, in_handler}, 32'd1);
        chk("tmr_req_drop", {31'd0, u_if.redirect_req}, 32'd0);
        tmr_req = 1'b0;
        pulse_mret();
        chk("tmr_ret_pc", u_if.redirect_pc, 32'h200);
        chk("tmr_ret_inh", {31'd0, in_handler}, 32'd0);
        ack_now();
        chk("tmr_ret_done", {31'd0, u_if.redirect_req}, 32'd0);
        cyc(2);

        // Three simultaneous edges: NMI, then TMR, then INT.
        pc_ret = 32'h300; en_int = 1'b1;
        nmi = 1'b1; tmr_req = 1'b1; int_req = 1'b1;
        serve("multi_nmi", 32'h100, 3'd0, 32'h300);
        serve("multi_tmr", 32'h120, 3'd2, 32'h300);
        serve("multi_int", 32'h130, 3'd3, 32'h300);
        nmi = 1'b0; tmr_req = 1'b0; int_req = 1'b0;
        cyc(2);

        // Masked INT stays pending until enabled.
        en_int = 1'b0; pc_ret = 32'h340; int_req = 1'b1;
        cyc(5);
        chk("int_masked", {31'd0, u_if.redirect_req}, 32'd0);
        en_int = 1'b1;
        cyc(1);
        chk("int_unmask_req", {31'd0, u_if.redirect_req}, 32'd1);
        chk("int_unmask_pc", u_if.redirect_pc, 32'h130);
        serve("int_late", 32'h130, 3'd3, 32'h340);
        int_req = 1'b0;
        cyc(2);

        // Masked ECALL is dropped; EBREAK ignores all enables.
        en_ecall = 1'b0;
        ecall = 1'b1; cyc(1); ecall = 1'b0;
        cyc(4);
        chk("ecall_dropped", {31'd0, u_if.redirect_req}, 32'd0);
        en_inter = 1'b0; en_tmr = 1'b0; en_int = 1'b0; pc_ret = 32'h400;
        ebreak = 1'b1; cyc(1); ebreak = 1'b0;
        chk("ebrk_req", {31'd0, u_if.redirect_req}, 32'd1);
        chk("ebrk_pc", u_if.redirect_pc, 32'h110);
        chk("ebrk_sel", {29'd0, trap_sel}, 32'd1);
        ack_now();
        pulse_mret();
        chk("mret_pc", u_if.redirect_pc, 32'h400);
        cyc(1);
        chk("mret_hold1", {31'd0, u_if.redirect_req}, 32'd1);
        cyc(1);
        chk("mret_hold2_pc", u_if.redirect_pc, 32'h400);
        ack_now();
        chk("mret_done", {31'd0, u_if.redirect_req}, 32'd0);
        cyc(2);

        // NMI inside a TMR handler waits for the return.
        en_inter = 1'b1; en_tmr = 1'b1; pc_ret = 32'h500; tmr_req = 1'b1;
        wait_req("nest_tmr", 8);
        chk("nest_tmr_pc", u_if.redirect_pc, 32'h120);
        ack_now();
        tmr_req = 1'b0; nmi = 1'b1;
        cyc(4);
        chk("nest_nmi_waits", {31'd0, u_if.redirect_req}, 32'd0);
        chk("nest_inh", {31'd0, in_handler}, 32'd1);
        pulse_mret();
        chk("nest_ret_pc", u_if.redirect_pc, 32'h500);
        chk("nest_ret_sel", {29'd0, trap_sel}, 32'd2);
        ack_now();
        serve("nest_nmi_after", 32'h100, 3'd0, 32'h500);
        nmi = 1'b0;
        cyc(2);

        // mret and NMI edge in the same cycle: mret wins.
        pc_ret = 32'h600; tmr_req = 1'b1;
        wait_req("race_tmr", 8);
        ack_now();
        tmr_req = 1'b0;
        cyc(1);
        nmi = 1'b1; mret = 1'b1;
        cyc(1);
        mret = 1'b0;
        chk("race_ret_pc", u_if.redirect_pc, 32'h600);
        chk("race_ret_sel", {29'd0, trap_sel}, 32'd2);
        ack_now();
        serve("race_nmi", 32'h100, 3'd0, 32'h600);
        nmi = 1'b0;
        cyc(2);

        // Reset during ENTER drops the redirect without an ack.
        ebreak = 1'b1; cyc(1); ebreak = 1'b0;
        chk("rst_mid_pre", {31'd0, u_if.redirect_req}, 32'd1);
        #3 rst = 1'b1;
        #1;
        chk("rst_mid_req", {31'd0, u_if.redirect_req}, 32'd0);
        chk("rst_mid_sel", {29'd0, trap_sel}, 32'd4);
        chk("rst_mid_epc", epc, 32'd0);
        @(negedge clk);
        #3 rst = 1'b0;
        cyc(3);
        chk("rst_mid_after", {31'd0, u_if.redirect_req}, 32'd0);

        cyc(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/irq_sequencer.md
# irq_sequencer

Sequences trap entry and return for the RV32IC core. Captures NMI, timer and external interrupt requests into pending latches, arbitrates them against synchronous ECALL/EBREAK events, and issues a registered PC redirect to fetch with a fixed vector. It saves the return PC, tracks handler occupancy, and replays the return redirect on MRET. It sits between decode/CSR enables and the fetch PC mux, and replaces ad hoc combinational trap selection in the core top.

## Interface
Parameters:
- VEC_BASE, 32'h0000_0100, base of trap vector table; entry = VEC_BASE + (trap_sel << 4)

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- nmi  in  1  non-maskable interrupt level; rising edge captured
- int_req  in  1  external interrupt level; rising edge captured
- tmr_req  in  1  timer interrupt level; rising edge captured
- ecall  in  1  one-cycle pulse from decode, valid ECALL
- ebreak  in  1  one-cycle pulse from decode, valid EBREAK
- mret  in  1  one-cycle pulse from decode, valid MRET
- pc_ret  in  32  return address supplied by decode for the current cycle
- en_inter, en_ecall, en_int, en_tmr  in  1 each  global and per-source enables
- redirect_ack  in  1  fetch accepted redirect this cycle
- redirect_req  out  1  redirect pending to fetch
- redirect_pc  out  32  redirect target
- trap_sel  out  3  source being served: NMI=0, EBREAK=1, TMR=2, INT=3, ECALL=4
- epc  out  32  saved return PC
- in_handler  out  1  core is executing a handler

## Operation
- Pending bits nmi_p, tmr_p, int_p are set on the rising edge of the input (registered previous value) and cleared only when that source is taken.
- Eligible sources: nmi_p; ebreak; tmr_p&en_tmr&en_inter; int_p&en_int&en_inter; ecall&en_ecall&en_inter. Priority is NMI > EBREAK > TMR > INT > ECALL.
- A disabled TMR or INT stays pending. A disabled ECALL, or an ECALL/EBREAK arriving outside IDLE, is dropped.
- States:
  - IDLE: if any source is eligible, latch trap_sel, set epc <= pc_ret, clear the chosen pending bit, go to ENTER.
  - ENTER: redirect_req=1, redirect_pc=vector; on redirect_ack go to HANDLER.
  - HANDLER: in_handler=1; on mret go to RETURN. Other sources remain pending.
  - RETURN: redirect_req=1, redirect_pc=epc; on redirect_ack go to IDLE.
- After RETURN, pending sources are re-arbitrated in IDLE on the next cycle.
- Simultaneous mret and NMI edge in HANDLER: mret wins and the NMI stays pending.
- Reset values: state IDLE, all pending bits 0, redirect_req=0, redirect_pc=0, trap_sel=3'd4, epc=0, in_handler=0.
- Reset asserted mid-operation aborts any redirect immediately; no ack is required.

## Timing
- Decision in IDLE at cycle N: redirect_req, redirect_pc, trap_sel and epc are valid from cycle N+1. All outputs are registered.
- A level input edge at cycle N sets pending at N+1, and the earliest redirect_req is at N+2.
- redirect_req holds with a stable redirect_pc until redirect_ack is sampled high. The state advances on the ack edge, and redirect_req is low in the following cycle.
- mret at cycle M in HANDLER: redirect_req=1 with redirect_pc=epc at M+1.
- in_handler rises the cycle after the ENTER ack and falls the cycle after mret.

## Configuration
- IRQ_NESTED_NMI_EN defined:
  - NMI_p in HANDLER (served source not NMI) preempts the handler. It saves epc2 <= pc_ret and enters NMI_ENTER, then NMI_HANDLER.
  - mret in NMI_HANDLER redirects to epc2 and returns to HANDLER, restoring trap_sel.
  - Only one nesting level exists. An NMI inside NMI_HANDLER stays pending.
- IRQ_NESTED_NMI_EN undefined: no nesting states or epc2. NMI in HANDLER waits until IDLE.

## Test plan
- tmr_req rises at cycle 10, en_tmr=en_inter=1, pc_ret=0x200 -> redirect_req at 12, redirect_pc=0x120, trap_sel=2, epc=0x200. Ack at 14 -> in_handler=1 at 15.
- nmi, tmr_req and int_req edges in the same cycle with all enables set -> NMI served first (pc 0x100). TMR is served after the first mret/return, and INT after the second.
- int_req edge with en_int=0 -> no redirect; set en_int=1 later -> redirect to 0x130 within 1 cycle.
- ecall pulse with en_ecall=0 -> dropped, no redirect; ebreak pulse with all enables 0 -> redirect to 0x110.
- In HANDLER with epc=0x400, pulse mret -> redirect_pc=0x400 next cycle, held for 3 cycles until ack, then IDLE. Assert rst during ENTER -> redirect_req=0 immediately.
- IRQ_NESTED_NMI_EN: an NMI in a TMR handler (pc_ret=0x500) -> redirect 0x100. mret -> redirect 0x500 with trap_sel=2. Without the macro, the NMI is taken only after the TMR return.
